// File: rtl/fifo_1r1w_small.sv
// Small single-clock FIFO: valid/ready on the write side, valid/yumi on the read side.
// Full and empty are told apart by an occupancy count.
module fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PW = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CW = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [CW-1:0]      cnt;
    logic               live;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(els_p));
    assign empty   = (cnt == '0);
    // live holds ready_o low until the first edge after reset release
    assign ready_o = live & ~full;
    assign v_o     = ~empty;
    assign data_o  = mem[rptr];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (enq) begin
                wptr <= bump(wptr);
            end
            if (deq) begin
                rptr <= bump(rptr);
            end
            if (enq && !deq) begin
                cnt <= cnt + 1'b1;
            end else if (deq && !enq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_1r1w_small.sv
// Bench for fifo_1r1w_small: a 4-entry and a 3-entry instance, scoreboard
// queues filled by the stimulus and drained by per-instance monitors.
module tb_fifo_1r1w_small;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v_a = 1'b0;
    logic [7:0] d_a = '0;
    logic       y_a = 1'b0;
    logic       rdy_a;
    logic       vo_a;
    logic [7:0] q_a;

    logic       v_b = 1'b0;
    logic [7:0] d_b = '0;
    logic       y_b;
    logic       stream_b = 1'b0;
    logic       rdy_b;
    logic       vo_b;
    logic [7:0] q_b;

    int checks = 0;
    int fails  = 0;
    int pops_b = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;

    assign y_b = stream_b & vo_b;

    fifo_1r1w_small #(.width_p(8), .els_p(4)) dut_a (
        .clk_i   (clk),
        .reset_i (rst_n),
        .v_i     (v_a),
        .ready_o (rdy_a),
        .data_i  (d_a),
        .v_o     (vo_a),
        .data_o  (q_a),
        .yumi_i  (y_a)
    );

    fifo_1r1w_small #(.width_p(8), .els_p(3)) dut_b (
        .clk_i   (clk),
        .reset_i (rst_n),
        .v_i     (v_b),
        .ready_o (rdy_b),
        .data_i  (d_b),
        .v_o     (vo_b),
        .data_o  (q_b),
        .yumi_i  (y_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && vo_a && y_a) begin
            if (exp_a.size() == 0) begin
                chk("a_unexpected_word", {24'd0, q_a}, 32'hffff_ffff);
            end else begin
                chk("a_data", {24'd0, q_a}, {24'd0, exp_a.pop_front()});
            end
        end
        if (rst_n && vo_b && y_b) begin
            pops_b++;
            if (exp_b.size() == 0) begin
                chk("b_unexpected_word", {24'd0, q_b}, 32'hffff_ffff);
            end else begin
                chk("b_data", {24'd0, q_b}, {24'd0, exp_b.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and idle
        repeat (3) tick();
        chk("rst_v_a", {31'd0, vo_a}, 32'd0);
        chk("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
        chk("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_rdy_a", {31'd0, rdy_a}, 32'd1);
        chk("rel_v_a", {31'd0, vo_a}, 32'd0);
        chk("rel_rdy_b", {31'd0, rdy_b}, 32'd1);

        // single word
        v_a = 1'b1; d_a = 8'hA5; exp_a.push_back(8'hA5);
        tick();
        v_a = 1'b0;
        chk("single_v", {31'd0, vo_a}, 32'd1);
        chk("single_data", {24'd0, q_a}, 32'h0000_00A5);
        y_a = 1'b1;
        tick();
        y_a = 1'b0;
        chk("single_empty", {31'd0, vo_a}, 32'd0);

        // fill and overflow
        for (int i = 1; i <= 4; i++) begin
            v_a = 1'b1; d_a = 8'(i); exp_a.push_back(8'(i));
            tick();
            if (i == 3) chk("rdy_at_3", {31'd0, rdy_a}, 32'd1);
        end
        chk("full_rdy", {31'd0, rdy_a}, 32'd0);
        d_a = 8'hFF;
        repeat (2) begin
            tick();
            chk("ovf_rdy", {31'd0, rdy_a}, 32'd0);
        end

        // full plus dequeue: write must be dropped
        y_a = 1'b1;
        tick();
        v_a = 1'b0; y_a = 1'b0;
        chk("fd_rdy", {31'd0, rdy_a}, 32'd1);
        chk("fd_v", {31'd0, vo_a}, 32'd1);
        y_a = 1'b1;
        repeat (3) tick();
        y_a = 1'b0;
        chk("drain_empty", {31'd0, vo_a}, 32'd0);
        chk("drain_sb_a", exp_a.size(), 32'd0);

        // wrap-around on the 3-entry instance
        stream_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            v_b = 1'b1; d_b = 8'(i); exp_b.push_back(8'(i));
            tick();
        end
        v_b = 1'b0;
        chk("stream_rate", pops_b, 32'd99);
        tick();
        chk("stream_count", pops_b, 32'd100);
        chk("stream_empty", {31'd0, vo_b}, 32'd0);
        stream_b = 1'b0;

        // reset mid-stream
        v_a = 1'b1; d_a = 8'h11; exp_a.push_back(8'h11);
        tick();
        d_a = 8'h22; exp_a.push_back(8'h22);
        tick();
        v_a = 1'b0;
        chk("pre_rst_v", {31'd0, vo_a}, 32'd1);
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        chk("async_rst_v", {31'd0, vo_a}, 32'd0);
        chk("async_rst_rdy", {31'd0, rdy_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel2_rdy", {31'd0, rdy_a}, 32'd1);
        chk("rel2_v", {31'd0, vo_a}, 32'd0);
        v_a = 1'b1; d_a = 8'h5A; exp_a.push_back(8'h5A);
        tick();
        v_a = 1'b0;
        chk("post_rst_data", {24'd0, q_a}, 32'h0000_005A);
        y_a = 1'b1;
        tick();
        y_a = 1'b0;
        chk("post_rst_empty", {31'd0, vo_a}, 32'd0);
        chk("final_sb_a", exp_a.size(), 32'd0);
        chk("final_sb_b", exp_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_1r1w_small.md
# fifo_1r1w_small

Small single-clock, one-read/one-write FIFO with valid/ready on the input and valid/yumi on the output. It buffers `els_p` words of `width_p` bits in order. It is the general-purpose elastic buffer between producers and consumers, for example the input-data and digest queues around the SHA-256 core (32 entries, 257-bit and 256-bit wide).

## Interface
- `width_p`, default 8: data width in bits; must be at least 1.
- `els_p`, default 4: number of entries; must be at least 2; need not be a power of two.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `reset_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `v_i`  in  1  producer has a valid word on `data_i`.
- `ready_o`  out  1  FIFO can accept a word this cycle.
- `data_i`  in  width_p  write data.
- `v_o`  out  1  `data_o` holds the oldest stored word.
- `data_o`  out  width_p  head-of-queue data.
- `yumi_i`  in  1  consumer takes the head word this cycle; legal only when `v_o`=1.

## Operation
- Storage: `els_p` x `width_p` register array. Write and read pointers each run from 0 to `els_p`-1. Occupancy is tracked by a count or a last-operation-was-write flag, so that full and empty are distinguished when the pointers are equal.
- Enqueue when `v_i` & `ready_o` at the rising edge:
  - `data_i` is written at the write pointer.
  - The write pointer advances; it wraps from `els_p`-1 to 0.
- A `v_i`=1 while `ready_o`=0 is ignored: no write and no state change.
- Dequeue when `yumi_i` & `v_o` at the rising edge: the read pointer advances with the same wrap rule.
- `yumi_i`=1 while `v_o`=0 is a protocol error. The FIFO ignores it: no pointer movement and no underflow.
- `ready_o` = not full, registered or derived only from state. It does not depend on `yumi_i`: when full, a same-cycle dequeue does not open a write slot.
- `v_o` = not empty. `data_o` = storage[read pointer], combinational from state.
- When `v_o`=0, `data_o` is unspecified and must not be checked.
- Simultaneous enqueue and dequeue with 0 < occupancy < `els_p`: both take effect and occupancy is unchanged.
- Simultaneous enqueue and dequeue at occupancy 0: impossible, because `v_o`=0.
- Simultaneous enqueue and dequeue at occupancy `els_p`: impossible, because `ready_o`=0.
- Ordering: words are output strictly in enqueue order. Nothing is duplicated or lost.
- Storage contents are not reset.

## Timing
- Reset asserted (`reset_i`=0), taking effect asynchronously:
  - Pointers and occupancy clear to zero.
  - `v_o`=0 and `ready_o`=0.
  - Inputs are ignored.
- First rising edge after deassertion: `ready_o`=1 and `v_o`=0.
- A reset asserted mid-operation discards all contents immediately. After release the FIFO is empty.
- Write-to-read latency is 1 cycle, with no fall-through. A word enqueued at edge N appears on `data_o` with `v_o`=1 after edge N; it can be dequeued at edge N+1 at the earliest.
- `ready_o` falls after the edge that stores the `els_p`-th word. It rises after the first dequeue edge from full.
- `v_o` falls after the edge that dequeues the last word, unless a write occurs at the same edge.
- Sustained throughput: one enqueue and one dequeue per cycle while not empty and not full.

## Test plan
- Reset then idle: drive `reset_i`=0 for 3 cycles, then release. Required: `v_o`=0 and `ready_o`=0 during reset; `ready_o`=1 and `v_o`=0 on the first cycle after release.
- Single word, `width_p`=8, `els_p`=4: enqueue 0xA5 at edge N. Required: `v_o`=1 and `data_o`=0xA5 after N. Pulse `yumi_i` at N+1. Required: `v_o`=0 after N+1.
- Fill and overflow, `els_p`=4: enqueue 0x01, 0x02, 0x03, 0x04 in back-to-back cycles. Required: `ready_o`=0 after the 4th. Hold `v_i`=1 with 0xFF for 2 cycles. Required: the dequeued sequence is exactly 0x01–0x04 and 0xFF never appears.
- Full plus dequeue: at full, assert `v_i` and `yumi_i` together. Required: the dequeue happens, the write is dropped, occupancy becomes 3, and `ready_o`=1 next cycle.
- Wrap-around, `els_p`=3 (non-power-of-two): stream 0..99 with `v_i`=1 and `yumi_i`=`v_o` every cycle. Required: the output sequence is 0..99 in order, with one word per cycle after the first.
- Reset mid-stream: with 2 words stored, pulse `reset_i` low between edges. Required: `v_o` drops immediately, and after release the next enqueued word 0x5A is the first dequeued.
